piso_ctrl: RTL and testbench



---
 rtl/piso_pkg.sv | 18 +
 rtl/piso_shift_dp.sv | 33 +++
 rtl/piso_ctrl.sv | 137 +++++++++++++
 tb/tb_piso_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in/serial-out controller.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  localparam int unsigned DEF_WIDTH        = 8;
  localparam int unsigned DEF_CLKS_PER_BIT = 4;

  // Bit-period counter width, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned clks_per_bit);
    return (clks_per_bit <= 32'd2) ? 32'd1 : 32'($clog2(clks_per_bit));
  endfunction

endpackage

// File: rtl/piso_shift_dp.sv
// WIDTH-bit shift register with synchronous clear, parallel load and
// directional shift; peek_c is the bit that reaches the serial end after the next shift.
module piso_shift_dp
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             shift_en,
  input  logic             dir,
  input  logic [WIDTH-1:0] din,
  output logic             peek_c
);

  logic [WIDTH-1:0] q;

  // dir=1 shifts toward the MSB end, dir=0 toward the LSB end.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift_en) begin
      q <= dir ? {q[WIDTH-2:0], 1'b0} : {1'b0, q[WIDTH-1:1]};
    end
  end

  assign peek_c = dir ? q[WIDTH-2] : q[1];

endmodule

// File: rtl/piso_ctrl.sv
// Parallel-in/serial-out sequencer: FSM, bit-period counter and bit index
// driving the shift datapath; every output is registered.
module piso_ctrl
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH        = DEF_WIDTH,
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     msb_first,
  input  logic [WIDTH-1:0]         din,
  output logic                     sout,
  output logic                     bit_valid,
  output logic [$clog2(WIDTH)-1:0] bit_idx,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned IW = $clog2(WIDTH);
  localparam int unsigned CW = cnt_width(CLKS_PER_BIT);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_d;
  logic            msb_q, msb_d;
  logic            sout_d, bv_d, busy_d, done_d;
  logic            dp_clr, dp_load, dp_shift, peek_c;

  piso_shift_dp #(.WIDTH(WIDTH)) u_dp (
    .clk      (clk),
    .rst      (rst),
    .clr      (dp_clr),
    .load     (dp_load),
    .shift_en (dp_shift),
    .dir      (msb_q),
    .din      (din),
    .peek_c   (peek_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      msb_q     <= 1'b0;
      sout      <= 1'b0;
      bit_valid <= 1'b0;
      bit_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      msb_q     <= msb_d;
      sout      <= sout_d;
      bit_valid <= bv_d;
      bit_idx   <= idx_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // Next state plus the next value of every registered output.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = bit_idx;
    msb_d    = msb_q;
    sout_d   = sout;
    bv_d     = 1'b0;
    busy_d   = busy;
    done_d   = 1'b0;
    dp_clr   = 1'b0;
    dp_load  = 1'b0;
    dp_shift = 1'b0;

    unique case (state_q)
      IDLE: begin
        sout_d = 1'b0;
        busy_d = 1'b0;
        if (start && !abort) begin
          dp_load = 1'b1;
          msb_d   = msb_first;
          state_d = SHIFT;
          cnt_d   = '0;
          idx_d   = '0;
          sout_d  = msb_first ? din[WIDTH-1] : din[0];
          bv_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end

      SHIFT: begin
        if (abort) begin
          dp_clr  = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
          sout_d  = 1'b0;
          busy_d  = 1'b0;
        end else if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d = '0;
          if (bit_idx == IW'(WIDTH - 1)) begin
            dp_clr  = 1'b1;
            state_d = DONE;
            idx_d   = '0;
            sout_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            dp_shift = 1'b1;
            idx_d    = bit_idx + IW'(1);
            sout_d   = peek_c;
            bv_d     = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
        sout_d  = 1'b0;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        sout_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_ctrl.sv
// Bench for piso_ctrl: two instances (4 and 1 clocks per bit) share stimulus and
// are checked every cycle against a transfer-timeline model, plus directed sequences.
module tb_piso_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start, abort, msb_first;
  logic [W-1:0] din;

  logic         sout4, bv4, busy4, done4;
  logic [2:0]   idx4;
  logic         sout1, bv1, busy1, done1;
  logic [2:0]   idx1;

  piso_ctrl #(.WIDTH(W), .CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .msb_first(msb_first),
    .din(din), .sout(sout4), .bit_valid(bv4), .bit_idx(idx4), .busy(busy4), .done(done4)
  );

  piso_ctrl #(.WIDTH(W), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .msb_first(msb_first),
    .din(din), .sout(sout1), .bit_valid(bv1), .bit_idx(idx1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    else
      passes++;
  endfunction

  // Model: a transfer is a timeline t = cycles since acceptance; bit k owns t in [k*cpb, (k+1)*cpb).
  int           cpb [2] = '{4, 1};
  bit           act [2];
  bit           dn  [2];
  int           t   [2];
  logic [W-1:0] word[2];
  bit           msb [2];

  function automatic void model_step(input int m);
    if (rst) begin
      act[m] = 0; dn[m] = 0; t[m] = 0;
    end else if (act[m]) begin
      if (abort) begin
        act[m] = 0; t[m] = 0;
      end else begin
        t[m]++;
        if (t[m] == W * cpb[m]) begin
          act[m] = 0; dn[m] = 1; t[m] = 0;
        end
      end
    end else if (dn[m]) begin
      dn[m] = 0;
    end else if (start && !abort) begin
      act[m] = 1; t[m] = 0; word[m] = din; msb[m] = msb_first;
    end
  endfunction

  function automatic void model_cmp(input int m, input logic so, input logic bv,
                                    input logic [2:0] ix, input logic bz, input logic dne);
    int k;
    logic e_sout;
    k = act[m] ? t[m] / cpb[m] : 0;
    e_sout = act[m] ? (msb[m] ? word[m][W-1-k] : word[m][k]) : 1'b0;
    chk($sformatf("cpb%0d.sout", cpb[m]), 32'(so), 32'(e_sout));
    chk($sformatf("cpb%0d.bit_valid", cpb[m]), 32'(bv), 32'(act[m] && (t[m] % cpb[m] == 0)));
    chk($sformatf("cpb%0d.bit_idx", cpb[m]), 32'(ix), 32'(k));
    chk($sformatf("cpb%0d.busy", cpb[m]), 32'(bz), 32'(act[m]));
    chk($sformatf("cpb%0d.done", cpb[m]), 32'(dne), 32'(dn[m]));
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    model_cmp(0, sout4, bv4, idx4, busy4, done4);
    model_cmp(1, sout1, bv1, idx1, busy1, done1);
  endtask

  task automatic idle_ticks(input int n);
    start = 0; abort = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct packed {
    logic       rst, start, abort, msb;
    logic [7:0] din;
    logic       e_busy, e_bv, e_sout, e_done;
    logic [2:0] e_idx;
  } vec_t;

  vec_t vecs[9];
  logic [7:0] seq_a5;
  int   acc[$];
  logic prev_busy;

  initial begin
    // Expected cpb=4 outputs after the edge that samples each row.
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};

    rst = 1; start = 0; abort = 0; msb_first = 0; din = '0;

    for (int i = 0; i < 9; i++) begin
      rst = vecs[i].rst; start = vecs[i].start; abort = vecs[i].abort;
      msb_first = vecs[i].msb; din = vecs[i].din;
      tick();
      chk($sformatf("vec%0d.busy", i), 32'(busy4), 32'(vecs[i].e_busy));
      chk($sformatf("vec%0d.bit_valid", i), 32'(bv4), 32'(vecs[i].e_bv));
      chk($sformatf("vec%0d.sout", i), 32'(sout4), 32'(vecs[i].e_sout));
      chk($sformatf("vec%0d.done", i), 32'(done4), 32'(vecs[i].e_done));
      chk($sformatf("vec%0d.bit_idx", i), 32'(idx4), 32'(vecs[i].e_idx));
    end
    rst = 0;
    idle_ticks(2);

    // 8'hA5 sent MSB-first and LSB-first both give 1,0,1,0,0,1,0,1.
    seq_a5 = 8'b1010_0101;

    // MSB-first, 4 clocks per bit.
    din = 8'hA5; msb_first = 1; start = 1;
    tick();
    start = 0;
    chk("msb.e0.sout", 32'(sout4), 32'(seq_a5[7]));
    chk("msb.e0.bit_valid", 32'(bv4), 32'd1);
    for (int e = 1; e <= 33; e++) begin
      tick();
      if (e < 32) begin
        chk($sformatf("msb.e%0d.sout", e), 32'(sout4), 32'(seq_a5[7 - e / 4]));
        chk($sformatf("msb.e%0d.bit_valid", e), 32'(bv4), 32'(e % 4 == 0));
        chk($sformatf("msb.e%0d.done", e), 32'(done4), 32'd0);
      end else if (e == 32) begin
        chk("msb.e32.done", 32'(done4), 32'd1);
        chk("msb.e32.busy", 32'(busy4), 32'd0);
        chk("msb.e32.sout", 32'(sout4), 32'd0);
      end else begin
        chk("msb.e33.done", 32'(done4), 32'd0);
      end
    end
    idle_ticks(2);

    // LSB-first, 1 clock per bit.
    din = 8'hA5; msb_first = 0; start = 1;
    tick();
    start = 0;
    chk("lsb.e0.sout", 32'(sout1), 32'(seq_a5[7]));
    for (int e = 1; e <= 9; e++) begin
      tick();
      if (e < 8) begin
        chk($sformatf("lsb.e%0d.sout", e), 32'(sout1), 32'(seq_a5[7 - e]));
        chk($sformatf("lsb.e%0d.bit_valid", e), 32'(bv1), 32'd1);
        chk($sformatf("lsb.e%0d.bit_idx", e), 32'(idx1), 32'(e));
      end else if (e == 8) begin
        chk("lsb.e8.done", 32'(done1), 32'd1);
        chk("lsb.e8.bit_valid", 32'(bv1), 32'd0);
      end else begin
        chk("lsb.e9.done", 32'(done1), 32'd0);
      end
    end
    idle_ticks(30);

    // Abort at edge 10, restart at edge 12.
    din = 8'hFF; msb_first = 1; start = 1;
    tick();
    start = 0;
    for (int e = 1; e <= 9; e++) tick();
    abort = 1;
    tick();
    abort = 0;
    chk("abort.e10.busy", 32'(busy4), 32'd0);
    chk("abort.e10.sout", 32'(sout4), 32'd0);
    chk("abort.e10.done", 32'(done4), 32'd0);
    tick();
    chk("abort.e11.done", 32'(done4), 32'd0);
    din = 8'hA5; start = 1;
    tick();
    start = 0;
    chk("abort.e12.busy", 32'(busy4), 32'd1);
    chk("abort.e12.sout", 32'(sout4), 32'd1);
    idle_ticks(40);

    // start held high: acceptances only once DONE has passed.
    din = 8'h3C; msb_first = 0; start = 1;
    prev_busy = busy4;
    for (int e = 0; e <= 75; e++) begin
      if (e == 5) din = 8'h00;
      if (e == 20) din = 8'h3C;
      tick();
      if (busy4 && !prev_busy) acc.push_back(e);
      prev_busy = busy4;
      if (e == 8) chk("hold.e8.sout", 32'(sout4), 32'd1);
    end
    chk("hold.accept_count", 32'(acc.size()), 32'd3);
    if (acc.size() == 3) begin
      chk("hold.accept0", 32'(acc[0]), 32'd0);
      chk("hold.accept1", 32'(acc[1]), 32'd34);
      chk("hold.accept2", 32'(acc[2]), 32'd68);
    end
    idle_ticks(40);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      rst       = ($urandom % 150) == 0;
      start     = ($urandom % 4) == 0;
      abort     = ($urandom % 40) == 0;
      msb_first = 1'($urandom);
      din       = 8'($urandom);
      tick();
    end
    rst = 0;
    idle_ticks(40);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
